lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store sequencer between the EX/MEM stage and the data-memory port.
- Takes decoded mem_read/mem_write/mem_op plus the ALU-computed address.
- Drives a req/gnt/rvalid data-memory handshake with byte enables.
- Stalls the pipeline until the access completes, and returns sign/zero-extended load data, misalignment flags and timeout bus errors.

Parameters:
- XLEN, 32, data/address width (from riscv_pkg).
- TIMEOUT_CYCLES, 64, cycles in REQ+WAIT_RESP before bus error; must be ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  instruction in stage is valid
- mem_read  in  1  decoded load
- mem_write  in  1  decoded store
- mem_op  in  mem_op_e  access size/signedness (MEM_BYTE, MEM_HALF, MEM_WORD, MEM_BYTE_U, MEM_HALF_U)
- addr  in  XLEN  effective byte address
- store_data  in  XLEN  rs2 value
- flush  in  1  squash current access (branch/trap redirect)
- stall  out  1  hold upstream pipeline
- load_data  out  XLEN  extended load result
- load_valid  out  1  one-cycle pulse, load_data valid
- store_done  out  1  one-cycle pulse, store acknowledged
- misaligned  out  1  one-cycle pulse, access rejected
- bus_err  out  1  one-cycle pulse, timeout
- dmem_req  out  1  request
- dmem_we  out  1  write enable
- dmem_addr  out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  XLEN  store data replicated into lanes
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  response valid (loads and stores)
- dmem_rdata  in  XLEN  read word

Behaviour:
- Reset: state IDLE, all pulses 0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0, load_data=0, counter=0, drop flag=0.
- FSM states: IDLE, REQ, WAIT_RESP.
- Start condition: start = ex_valid & (mem_read|mem_write) & !flush in IDLE.
  - mem_read and mem_write both set: treat as load.
- Misalignment check:
  - HALF/HALF_U: addr[0]=1 is misaligned.
  - WORD: addr[1:0]≠0 is misaligned.
  - Misaligned start: misaligned pulses next cycle, no request, stall=0, stay IDLE.
- Aligned start (cycle N):
  - Register op, byte offset, dmem_* fields; go to REQ.
  - stall=1 combinationally in cycle N.
  - dmem_req=1 from N+1.
- Byte enables:
  - BYTE: 4'b0001<<addr[1:0].
  - HALF: 4'b0011<<addr[1:0].
  - WORD: 4'b1111.
- Write data: byte replicated ×4, half ×2.
- REQ:
  - dmem_req and all dmem_* held stable until dmem_gnt.
  - On gnt: dmem_req=0 next cycle, go to WAIT_RESP.
- WAIT_RESP, on dmem_rvalid → IDLE, next cycle:
  - Load: load_data = lane selected by offset, sign-extended (BYTE/HALF) or zero-extended (_U); load_valid=1.
  - Store: store_done=1.
  - stall=0 in that pulse cycle.
- rvalid in the same cycle as gnt: ignored; response must arrive ≥1 cycle after gnt.
- stall:
  - 1 in REQ and WAIT_RESP.
  - 0 in IDLE except the accept cycle.
- Timeout:
  - Counter clears on accept and increments each cycle in REQ/WAIT_RESP.
  - When it reaches TIMEOUT_CYCLES-1 without completion: bus_err pulse next cycle, dmem_req dropped, go to IDLE.
  - A late rvalid after timeout is ignored.
- Flush:
  - In REQ before gnt: drop dmem_req next cycle, go to IDLE, no pulses.
  - Flush in REQ coincident with gnt, or in WAIT_RESP: set drop flag. Still wait for rvalid (or timeout), then suppress load_valid/store_done/bus_err. stall=0 while dropping.
  - Flush in IDLE: no effect.
- Back-to-back: a new start is accepted in the IDLE cycle carrying the previous load_valid.
- Pulses never overlap; at most one of load_valid/store_done/misaligned/bus_err per cycle.
- Reset mid-transaction: immediate return to IDLE with reset values next cycle; any outstanding response is then ignored while IDLE.

Decomposition:
- riscv_pkg additions:
  - lsu_state_e {LSU_IDLE, LSU_REQ, LSU_WAIT_RESP}.
  - LSU_TIMEOUT_DEFAULT constant.
- Reuse the existing mem_op_e.
- One sub-module: lsu_align (combinational). Computes be/wdata lane placement from mem_op/offset, and load extraction/extension from rdata.

Test Plan:
- LW addr=0x100, gnt at N+1, rvalid at N+3, rdata=0xDEADBEEF
  -> dmem_addr=0x100, be=1111, load_data=0xDEADBEEF with load_valid at N+4, stall high N..N+3.
- LB addr=0x103, rdata=0x80FF_0000 -> be=1000, load_data=0xFFFFFF80. LBU same -> 0x00000080. LHU addr=0x102 -> be=1100, load_data=0x000080FF.
- SB addr=0x201, store_data=0x12345678
  -> we=1, be=0010, wdata=0x78787878, store_done after rvalid, no load_valid.
- LH addr=0x101 and LW addr=0x102 -> misaligned pulse, dmem_req never asserted, stall low after accept cycle.
- gnt held low with TIMEOUT_CYCLES=8 -> bus_err pulse 8 cycles after accept, dmem_req drops. A later rvalid produces no pulse.
- Flush in WAIT_RESP, then rvalid -> no load_valid, stall low. Next LW is accepted and completes normally. Reset asserted in REQ -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core definitions: XLEN, memory access encodings and the load/store unit state type.
package riscv_pkg;

    localparam int RV_XLEN             = 32;
    localparam int LSU_TIMEOUT_DEFAULT = 64;

    typedef enum logic [2:0] {
        MEM_BYTE   = 3'd0,
        MEM_HALF   = 3'd1,
        MEM_WORD   = 3'd2,
        MEM_BYTE_U = 3'd4,
        MEM_HALF_U = 3'd5
    } mem_op_e;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT_RESP
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Lane placement for stores (byte enables, replicated write data, alignment check)
// and lane extraction with sign/zero extension for load responses.
module lsu_align
    import riscv_pkg::*;
#(
    parameter int XLEN = RV_XLEN
) (
    input  mem_op_e           req_op,
    input  logic [1:0]        req_offset,
    input  logic [XLEN-1:0]   store_data,
    output logic              req_misaligned,
    output logic [3:0]        req_be,
    output logic [XLEN-1:0]   req_wdata,
    input  mem_op_e           rsp_op,
    input  logic [1:0]        rsp_offset,
    input  logic [XLEN-1:0]   rdata,
    output logic [XLEN-1:0]   load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    function automatic logic [XLEN-1:0] sext_byte(input logic signed [7:0] v);
        logic signed [XLEN-1:0] r;
        r = v;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] sext_half(input logic signed [15:0] v);
        logic signed [XLEN-1:0] r;
        r = v;
        return r;
    endfunction

    always_comb begin
        req_misaligned = 1'b0;
        req_be         = 4'b1111;
        req_wdata      = store_data;
        unique case (req_op)
            MEM_BYTE, MEM_BYTE_U: begin
                req_be    = 4'b0001 << req_offset;
                req_wdata = {4{store_data[7:0]}};
            end
            MEM_HALF, MEM_HALF_U: begin
                req_misaligned = req_offset[0];
                req_be         = 4'b0011 << req_offset;
                req_wdata      = {2{store_data[15:0]}};
            end
            default: begin
                req_misaligned = |req_offset;
            end
        endcase
    end

    // Response lanes: the byte at the offset, the half-word at the even offset.
    always_comb begin
        byte_sel = rdata[{rsp_offset, 3'b000} +: 8];
        half_sel = rdata[{rsp_offset[1], 4'b0000} +: 16];
        unique case (rsp_op)
            MEM_BYTE:   load_data = sext_byte(byte_sel);
            MEM_BYTE_U: load_data = {{(XLEN-8){1'b0}}, byte_sel};
            MEM_HALF:   load_data = sext_half(half_sel);
            MEM_HALF_U: load_data = {{(XLEN-16){1'b0}}, half_sel};
            default:    load_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: accepts one access from EX/MEM, runs the req/gnt/rvalid
// data-memory handshake, stalls the pipeline meanwhile and reports the outcome as a pulse.
module lsu_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN           = RV_XLEN,
    parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  mem_op_e           mem_op,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   store_data,
    input  logic              flush,
    output logic              stall,
    output logic [XLEN-1:0]   load_data,
    output logic              load_valid,
    output logic              store_done,
    output logic              misaligned,
    output logic              bus_err,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    lsu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              drop_q;
    mem_op_e           op_p1;
    logic [1:0]        off_p1;
    logic              is_load_p1;

    logic              accept, misal_start, complete, timeout, set_drop;
    logic              cnt_hit, drop_now;
    logic              req_misaligned;
    logic [3:0]        req_be;
    logic [XLEN-1:0]   req_wdata, ext_data;

    lsu_align #(.XLEN(XLEN)) u_align (
        .req_op         (mem_op),
        .req_offset     (addr[1:0]),
        .store_data     (store_data),
        .req_misaligned (req_misaligned),
        .req_be         (req_be),
        .req_wdata      (req_wdata),
        .rsp_op         (op_p1),
        .rsp_offset     (off_p1),
        .rdata          (dmem_rdata),
        .load_data      (ext_data)
    );

    // The counter hits one cycle early so the bus_err pulse lands TIMEOUT_CYCLES after accept.
    assign cnt_hit  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 2));
    assign drop_now = drop_q | flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LSU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        stall       = 1'b0;
        accept      = 1'b0;
        misal_start = 1'b0;
        complete    = 1'b0;
        timeout     = 1'b0;
        set_drop    = 1'b0;
        unique case (state_q)
            LSU_IDLE: begin
                if (ex_valid && (mem_read || mem_write) && !flush) begin
                    if (req_misaligned) begin
                        misal_start = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        stall   = 1'b1;
                        state_d = LSU_REQ;
                    end
                end
            end
            LSU_REQ: begin
                stall = 1'b1;
                if (flush && !dmem_gnt) begin
                    state_d = LSU_IDLE;
                end else if (cnt_hit) begin
                    timeout = 1'b1;
                    state_d = LSU_IDLE;
                end else if (dmem_gnt) begin
                    set_drop = flush;
                    state_d  = LSU_WAIT_RESP;
                end
            end
            LSU_WAIT_RESP: begin
                stall    = !drop_q;
                set_drop = flush;
                if (dmem_rvalid) begin
                    complete = 1'b1;
                    state_d  = LSU_IDLE;
                end else if (cnt_hit) begin
                    timeout = 1'b1;
                    state_d = LSU_IDLE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            drop_q     <= 1'b0;
            op_p1      <= MEM_BYTE;
            off_p1     <= 2'b00;
            is_load_p1 <= 1'b0;
            load_data  <= '0;
            load_valid <= 1'b0;
            store_done <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= 4'b0000;
            dmem_wdata <= '0;
        end else begin
            load_valid <= 1'b0;
            store_done <= 1'b0;
            misaligned <= misal_start;
            bus_err    <= timeout && !drop_now;

            if (accept) begin
                cnt_q      <= '0;
                op_p1      <= mem_op;
                off_p1     <= addr[1:0];
                is_load_p1 <= mem_read;
                dmem_req   <= 1'b1;
                dmem_we    <= !mem_read;
                dmem_addr  <= {addr[XLEN-1:2], 2'b00};
                dmem_be    <= req_be;
                dmem_wdata <= req_wdata;
            end else if (state_q != LSU_IDLE) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (state_q == LSU_REQ && state_d != LSU_REQ) begin
                dmem_req <= 1'b0;
                dmem_we  <= 1'b0;
            end

            if (state_d == LSU_IDLE) begin
                drop_q <= 1'b0;
            end else if (set_drop) begin
                drop_q <= 1'b1;
            end

            if (complete && !drop_now) begin
                if (is_load_p1) begin
                    load_valid <= 1'b1;
                    load_data  <= ext_data;
                end else begin
                    store_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: expected completion pulses are queued when an access is
// issued and matched against the pulse the DUT raises.
module tb_lsu_ctrl;
    import riscv_pkg::*;

    localparam int XLEN = 32;
    localparam int TMO  = 8;

    localparam logic [3:0] K_LOAD  = 4'b1000;
    localparam logic [3:0] K_STORE = 4'b0100;
    localparam logic [3:0] K_MIS   = 4'b0010;
    localparam logic [3:0] K_BERR  = 4'b0001;

    logic            clk = 1'b0;
    logic            rst;
    logic            ex_valid, mem_read, mem_write, flush;
    mem_op_e         mem_op;
    logic [XLEN-1:0] addr, store_data;
    logic            stall, load_valid, store_done, misaligned, bus_err;
    logic [XLEN-1:0] load_data;
    logic            dmem_req, dmem_we;
    logic [XLEN-1:0] dmem_addr, dmem_wdata;
    logic [3:0]      dmem_be;
    logic            dmem_gnt, dmem_rvalid;
    logic [XLEN-1:0] dmem_rdata;
    logic [3:0]      pulse_vec;

    always #5 clk = ~clk;

    lsu_ctrl #(.XLEN(XLEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_read(mem_read), .mem_write(mem_write),
        .mem_op(mem_op), .addr(addr), .store_data(store_data), .flush(flush), .stall(stall),
        .load_data(load_data), .load_valid(load_valid), .store_done(store_done),
        .misaligned(misaligned), .bus_err(bus_err), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );

    assign pulse_vec = {load_valid, store_done, misaligned, bus_err};

    typedef struct packed {
        logic [3:0]  kind;
        logic [31:0] data;
    } exp_t;

    exp_t  sb[$];
    string sb_tag[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ex_valid    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_op      = MEM_WORD;
        addr        = '0;
        store_data  = '0;
        flush       = 1'b0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
    endtask

    task automatic drive_start(input mem_op_e op, input logic rd, input logic wr,
                               input logic [31:0] a, input logic [31:0] sd);
        ex_valid   = 1'b1;
        mem_read   = rd;
        mem_write  = wr;
        mem_op     = op;
        addr       = a;
        store_data = sd;
    endtask

    task automatic push_exp(input string tag, input logic [3:0] kind, input logic [31:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        sb.push_back(e);
        sb_tag.push_back(tag);
    endtask

    // Called just after a posedge; looks for a pulse within the budget of cycles.
    task automatic expect_pulse(input int budget);
        exp_t  e;
        string tag;
        bit    seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            sample();
            if (pulse_vec != 4'b0000) begin
                seen = 1'b1;
                break;
            end
            next();
        end
        if (sb.size() == 0) begin
            n_checks++;
            $error("FAIL scoreboard: observed pulse %b expected none queued", pulse_vec);
        end else begin
            e   = sb.pop_front();
            tag = sb_tag.pop_front();
            if (!seen) begin
                n_checks++;
                $error("FAIL %s.pulse: observed no pulse in %0d cycles expected %b", tag, budget, e.kind);
            end else begin
                check({tag, ".kind"}, {28'd0, pulse_vec}, {28'd0, e.kind});
                check({tag, ".stall_done"}, {31'd0, stall}, 32'd0);
                if (e.kind == K_LOAD) check({tag, ".data"}, load_data, e.data);
            end
        end
    endtask

    // Aligned access: gnt at N+1 (with a stray rvalid that must be ignored), rvalid at N+3.
    task automatic access(input string tag, input mem_op_e op, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [3:0] kind, input logic [31:0] exp_data);
        next();
        drive_start(op, rd, wr, a, sd);
        push_exp(tag, kind, exp_data);
        sample();
        check({tag, ".stall_acc"}, {31'd0, stall}, 32'd1);
        next();
        idle_inputs();
        dmem_gnt    = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hBAD0_BAD0;
        sample();
        check({tag, ".req"}, {31'd0, dmem_req}, 32'd1);
        check({tag, ".addr"}, dmem_addr, {a[31:2], 2'b00});
        check({tag, ".be"}, {28'd0, dmem_be}, {28'd0, exp_be});
        check({tag, ".we"}, {31'd0, dmem_we}, {31'd0, wr & ~rd});
        check({tag, ".wdata"}, dmem_wdata, exp_wdata);
        next();
        idle_inputs();
        sample();
        check({tag, ".req_drop"}, {31'd0, dmem_req}, 32'd0);
        check({tag, ".no_early"}, {28'd0, pulse_vec}, 32'd0);
        next();
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        sample();
        check({tag, ".stall_wait"}, {31'd0, stall}, 32'd1);
        next();
        idle_inputs();
        expect_pulse(1);
    endtask

    task automatic misaligned_access(input string tag, input mem_op_e op, input logic [31:0] a);
        next();
        drive_start(op, 1'b1, 1'b0, a, 32'd0);
        push_exp(tag, K_MIS, 32'd0);
        next();
        idle_inputs();
        expect_pulse(1);
        check({tag, ".req"}, {31'd0, dmem_req}, 32'd0);
        next();
        sample();
        check({tag, ".req_after"}, {31'd0, dmem_req}, 32'd0);
        check({tag, ".stall_after"}, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        next();
        next();
        sample();
        check("rst.pulses", {28'd0, pulse_vec}, 32'd0);
        check("rst.req_we_be", {26'd0, dmem_req, dmem_we, dmem_be}, 32'd0);
        check("rst.addr", dmem_addr, 32'd0);
        check("rst.wdata", dmem_wdata, 32'd0);
        check("rst.load_data", load_data, 32'd0);
        check("rst.stall", {31'd0, stall}, 32'd0);
        next();
        rst = 1'b0;

        access("lw",  MEM_WORD,   1'b1, 1'b0, 32'h100, 32'd0, 32'hDEADBEEF, 4'b1111, 32'd0, K_LOAD, 32'hDEADBEEF);
        access("lb",  MEM_BYTE,   1'b1, 1'b0, 32'h103, 32'd0, 32'h80FF0000, 4'b1000, 32'd0, K_LOAD, 32'hFFFFFF80);
        access("lbu", MEM_BYTE_U, 1'b1, 1'b0, 32'h103, 32'd0, 32'h80FF0000, 4'b1000, 32'd0, K_LOAD, 32'h00000080);
        access("lhu", MEM_HALF_U, 1'b1, 1'b0, 32'h102, 32'd0, 32'h80FF0000, 4'b1100, 32'd0, K_LOAD, 32'h000080FF);
        access("sb",  MEM_BYTE,   1'b0, 1'b1, 32'h201, 32'h12345678, 32'd0, 4'b0010, 32'h78787878, K_STORE, 32'd0);
        access("sh",  MEM_HALF,   1'b0, 1'b1, 32'h202, 32'h0000ABCD, 32'd0, 4'b1100, 32'hABCDABCD, K_STORE, 32'd0);
        access("rw",  MEM_BYTE,   1'b1, 1'b1, 32'h000, 32'h11111111, 32'h000000F0, 4'b0001, 32'h11111111, K_LOAD, 32'hFFFFFFF0);

        misaligned_access("mis_lh", MEM_HALF, 32'h101);
        misaligned_access("mis_lw", MEM_WORD, 32'h102);

        // Timeout with gnt held low: bus_err TMO cycles after accept.
        next();
        drive_start(MEM_WORD, 1'b1, 1'b0, 32'h300, 32'd0);
        push_exp("tmo", K_BERR, 32'd0);
        next();
        idle_inputs();
        for (int i = 2; i <= TMO - 1; i++) next();
        sample();
        check("tmo.req_held", {31'd0, dmem_req}, 32'd1);
        check("tmo.no_early", {28'd0, pulse_vec}, 32'd0);
        next();
        expect_pulse(1);
        check("tmo.req_drop", {31'd0, dmem_req}, 32'd0);
        next();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h5555AAAA;
        next();
        idle_inputs();
        sample();
        check("tmo.late_rvalid", {28'd0, pulse_vec}, 32'd0);

        // Flush while waiting for the response.
        next();
        drive_start(MEM_WORD, 1'b1, 1'b0, 32'h104, 32'd0);
        next();
        idle_inputs();
        dmem_gnt = 1'b1;
        next();
        dmem_gnt = 1'b0;
        flush    = 1'b1;
        next();
        flush = 1'b0;
        sample();
        check("flw.stall_drop", {31'd0, stall}, 32'd0);
        next();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h12121212;
        next();
        idle_inputs();
        sample();
        check("flw.no_pulse", {28'd0, pulse_vec}, 32'd0);
        check("flw.stall", {31'd0, stall}, 32'd0);

        access("lh_after", MEM_HALF, 1'b1, 1'b0, 32'h102, 32'd0, 32'h80011234, 4'b1100, 32'd0, K_LOAD, 32'hFFFF8001);

        // Flush in REQ before gnt.
        next();
        drive_start(MEM_WORD, 1'b1, 1'b0, 32'h108, 32'd0);
        next();
        idle_inputs();
        flush = 1'b1;
        next();
        flush = 1'b0;
        sample();
        check("flr.req", {31'd0, dmem_req}, 32'd0);
        check("flr.stall", {31'd0, stall}, 32'd0);
        next();
        sample();
        check("flr.no_pulse", {28'd0, pulse_vec}, 32'd0);

        // Reset in REQ.
        next();
        drive_start(MEM_BYTE, 1'b0, 1'b1, 32'h10D, 32'h000000AB);
        next();
        idle_inputs();
        rst = 1'b1;
        next();
        rst = 1'b0;
        sample();
        check("rstreq.req_we_be", {26'd0, dmem_req, dmem_we, dmem_be}, 32'd0);
        check("rstreq.addr", dmem_addr, 32'd0);
        check("rstreq.wdata", dmem_wdata, 32'd0);
        check("rstreq.load_data", load_data, 32'd0);
        check("rstreq.stall", {31'd0, stall}, 32'd0);
        next();
        dmem_rvalid = 1'b1;
        next();
        idle_inputs();
        sample();
        check("rstreq.no_pulse", {28'd0, pulse_vec}, 32'd0);

        check("sb.empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
